// File: rtl/cpu_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package cpu_fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSN_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_fetch_queue_if.sv
// Fetch-to-decode valid/ready handshake carrying the queue head entry.
interface cpu_fetch_queue_if;
    import cpu_fetch_pkg::*;

    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
    logic            empty;

    modport master (
        output valid,
        output pc,
        output instruction,
        output empty,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  instruction,
        input  empty,
        output ready
    );

endinterface

// File: rtl/cpu_fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with flush and a zero-latency head read.
module cpu_fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_wdata,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Pointers wrap naturally at their DEPTH_LOG2-bit width.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Head reads as zero while empty so stale storage never leaks to decode.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/cpu_fetch_queue.sv
// Fetch stage: owns the fetch PC, queues cache hits for decode, handles redirects.
// Optional performance counters are enabled with CPU_FETCH_PERF_COUNTERS_EN.
module cpu_fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH_LOG2   = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    output logic [XLEN-1:0]     o_icache_pc,
    input  logic                i_icache_ready,
    input  logic [XLEN-1:0]     i_icache_rdata,
    input  logic                i_redirect,
    input  logic [XLEN-1:0]     i_redirect_pc,
    cpu_fetch_queue_if.master   dec
`ifdef CPU_FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]         o_perf_fetched,
    output logic [31:0]         o_perf_miss_stall,
    output logic [31:0]         o_perf_full_stall
`endif
);

    logic [XLEN-1:0] r_pc;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_wdata;
    fetch_entry_t    w_head;

    // Redirect squashes both the incoming cache word and the head handoff.
    assign w_push  = i_icache_ready && !w_full && !i_redirect;
    assign w_pop   = !w_empty && dec.ready && !i_redirect;
    assign w_wdata = '{pc: r_pc, instruction: i_icache_rdata};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_VECTOR;
        end else if (i_redirect) begin
            r_pc <= align_pc(i_redirect_pc);
        end else if (w_push) begin
            r_pc <= r_pc + XLEN'(INSN_BYTES);
        end
    end

    cpu_fetch_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (i_redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_icache_pc     = r_pc;
    assign dec.valid       = !w_empty;
    assign dec.empty       = w_empty;
    assign dec.pc          = w_head.pc;
    assign dec.instruction = w_head.instruction;

`ifdef CPU_FETCH_PERF_COUNTERS_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_miss_stall;
    logic [31:0] r_perf_full_stall;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_perf_fetched    <= '0;
            r_perf_miss_stall <= '0;
            r_perf_full_stall <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'(1);
            end
            if (!i_icache_ready && !w_full && !i_redirect) begin
                r_perf_miss_stall <= r_perf_miss_stall + 32'(1);
            end
            if (i_icache_ready && w_full) begin
                r_perf_full_stall <= r_perf_full_stall + 32'(1);
            end
        end
    end

    assign o_perf_fetched    = r_perf_fetched;
    assign o_perf_miss_stall = r_perf_miss_stall;
    assign o_perf_full_stall = r_perf_full_stall;
`endif

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Self-checking bench for cpu_fetch_queue: queue-based reference model plus directed literal checks.
module tb_cpu_fetch_queue;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;
    localparam int          DEPTH = 4;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] o_icache_pc;
    logic        i_icache_ready;
    logic [31:0] i_icache_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    cpu_fetch_queue_if dec_if ();

`ifdef CPU_FETCH_PERF_COUNTERS_EN
    logic [31:0] o_perf_fetched;
    logic [31:0] o_perf_miss_stall;
    logic [31:0] o_perf_full_stall;
`endif

    cpu_fetch_queue #(
        .RESET_VECTOR (RV),
        .DEPTH_LOG2   (2)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .o_icache_pc    (o_icache_pc),
        .i_icache_ready (i_icache_ready),
        .i_icache_rdata (i_icache_rdata),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .dec            (dec_if)
`ifdef CPU_FETCH_PERF_COUNTERS_EN
        ,
        .o_perf_fetched    (o_perf_fetched),
        .o_perf_miss_stall (o_perf_miss_stall),
        .o_perf_full_stall (o_perf_full_stall)
`endif
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Behavioural cache: every address hits with a recognisable word when ready.
    assign i_icache_rdata = o_icache_pc ^ KEY;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {pc, instruction} plus the fetch PC.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetched, m_miss, m_fullst;

    always @(negedge i_clock) begin
        bit m_full, m_push, m_pop;
        if (i_reset) begin
            m_q.delete();
            m_pc = RV;
            m_fetched = 0; m_miss = 0; m_fullst = 0;
        end
        chk("icache_pc", o_icache_pc, m_pc);
        chk("valid", 32'(dec_if.valid), 32'(m_q.size() != 0));
        chk("empty", 32'(dec_if.empty), 32'(m_q.size() == 0));
        chk("head_pc", dec_if.pc, (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
        chk("head_insn", dec_if.instruction, (m_q.size() != 0) ? m_q[0][31:0] : 32'h0);
`ifdef CPU_FETCH_PERF_COUNTERS_EN
        chk("perf_fetched", o_perf_fetched, m_fetched);
        chk("perf_miss", o_perf_miss_stall, m_miss);
        chk("perf_full", o_perf_full_stall, m_fullst);
`endif
        if (!i_reset) begin
            m_full = (m_q.size() == DEPTH);
            m_push = i_icache_ready && !m_full && !i_redirect;
            m_pop  = (m_q.size() != 0) && dec_if.ready && !i_redirect;
            if (m_push) m_fetched = m_fetched + 1;
            if (!i_icache_ready && !m_full && !i_redirect) m_miss = m_miss + 1;
            if (i_icache_ready && m_full) m_fullst = m_fullst + 1;
            if (i_redirect) begin
                m_q.delete();
                m_pc = i_redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) begin
                    m_q.push_back({m_pc, m_pc ^ KEY});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

`ifdef CPU_FETCH_PERF_COUNTERS_EN
    logic [31:0] miss_base;
`endif

    initial begin
        i_reset        = 1'b1;
        i_icache_ready = 1'b0;
        i_redirect     = 1'b0;
        i_redirect_pc  = 32'h0;
        dec_if.ready   = 1'b0;
        step();
        step();
        chk("rst_pc", o_icache_pc, RV);
        chk("rst_valid", 32'(dec_if.valid), 32'd0);
        chk("rst_empty", 32'(dec_if.empty), 32'd1);
        chk("rst_head_pc", dec_if.pc, 32'h0);

        // Streaming hits with decode always ready.
        i_icache_ready = 1'b1;
        dec_if.ready   = 1'b1;
        i_reset        = 1'b0;
        @(negedge i_clock); #1;
        chk("stream0_pc", o_icache_pc, 32'h0);
        chk("stream0_valid", 32'(dec_if.valid), 32'd0);
        @(negedge i_clock); #1;
        chk("stream1_pc", o_icache_pc, 32'h4);
        chk("stream1_valid", 32'(dec_if.valid), 32'd1);
        chk("stream1_head", dec_if.pc, 32'h0);
        chk("stream1_insn", dec_if.instruction, 32'hA5A5_A5A5);
        @(negedge i_clock); #1;
        chk("stream2_pc", o_icache_pc, 32'h8);
        chk("stream2_head", dec_if.pc, 32'h4);
        repeat (6) step();

        // Cache miss held for five cycles at 0x40.
        i_redirect = 1'b1; i_redirect_pc = 32'h40; i_icache_ready = 1'b0;
        step();
        i_redirect = 1'b0;
`ifdef CPU_FETCH_PERF_COUNTERS_EN
        miss_base = o_perf_miss_stall;
`endif
        repeat (5) begin
            step();
            chk("miss_pc_hold", o_icache_pc, 32'h40);
        end
`ifdef CPU_FETCH_PERF_COUNTERS_EN
        chk("miss_stall_5", o_perf_miss_stall - miss_base, 32'd5);
`endif
        i_icache_ready = 1'b1;
        step();
        chk("miss_push_valid", 32'(dec_if.valid), 32'd1);
        chk("miss_push_pc", dec_if.pc, 32'h40);
        step();
        chk("miss_next_pc", dec_if.pc, 32'h44);

        // Fill with decode stalled, then drain.
        dec_if.ready = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        step();
        i_redirect = 1'b0;
        repeat (4) step();
        chk("fill_pc", o_icache_pc, 32'h210);
        chk("fill_head", dec_if.pc, 32'h200);
        step();
        chk("full_hold_pc", o_icache_pc, 32'h210);
        dec_if.ready = 1'b1;
        step();
        chk("drain_head1", dec_if.pc, 32'h204);
        chk("drain_pc1", o_icache_pc, 32'h210);
        step();
        chk("drain_head2", dec_if.pc, 32'h208);
        chk("drain_pc2", o_icache_pc, 32'h214);

        // Redirect with three entries queued and decode ready.
        dec_if.ready = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'h300;
        step();
        i_redirect = 1'b0;
        repeat (3) step();
        dec_if.ready = 1'b1;
        i_redirect = 1'b1; i_redirect_pc = 32'h1000;
        step();
        i_redirect = 1'b0;
        chk("redir_valid", 32'(dec_if.valid), 32'd0);
        chk("redir_pc", o_icache_pc, 32'h1000);
        step();
        chk("redir_first", dec_if.pc, 32'h1000);

        // Address wrap, also exercising dropped low target bits.
        dec_if.ready = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
        step();
        i_redirect = 1'b0;
        chk("wrap_target", o_icache_pc, 32'hFFFF_FFFC);
        step();
        step();
        chk("wrap_pc", o_icache_pc, 32'h4);
        chk("wrap_head", dec_if.pc, 32'hFFFF_FFFC);
        chk("wrap_insn", dec_if.instruction, 32'h5A5A_5A59);
        dec_if.ready = 1'b1;
        step();
        chk("wrap_head2", dec_if.pc, 32'h0);
        chk("wrap_insn2", dec_if.instruction, 32'hA5A5_A5A5);

        // Asynchronous reset in the middle of a fill.
        dec_if.ready = 1'b0;
        repeat (2) step();
        #1;
        i_reset = 1'b1;
        #1;
        chk("async_valid", 32'(dec_if.valid), 32'd0);
        chk("async_pc", o_icache_pc, RV);
        chk("async_empty", 32'(dec_if.empty), 32'd1);
        step();
        i_reset = 1'b0;

        // Randomized traffic against the model.
        repeat (3000) begin
            i_icache_ready = ($urandom % 4) != 0;
            dec_if.ready   = ($urandom % 5) < 3;
            i_redirect     = ($urandom % 32) == 0;
            i_redirect_pc  = $urandom;
            step();
        end
        i_redirect = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
